// File: rtl/motoro3_commutator_ramp_pkg.sv
// ---------------------------------------------------------------------------
// motoro3_commutator_ramp_pkg : state codes, six-step drive table, step helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package motoro3_commutator_ramp_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DEAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_BRAKE = 2'd3;

   localparam logic [3:0] STEP_MAX = 4'd5;

   typedef struct packed {
      logic a_e;
      logic a_h;
      logic b_e;
      logic b_h;
      logic c_e;
      logic c_h;
   } drive_t;

   // Each entry lists {aE,aH,bE,bH,cE,cH}; the undriven phase stays 00.
   localparam drive_t DRV_OFF   = 6'b00_00_00;
   localparam drive_t DRV_S0    = 6'b11_10_00;
   localparam drive_t DRV_S1    = 6'b11_00_10;
   localparam drive_t DRV_S2    = 6'b00_11_10;
   localparam drive_t DRV_S3    = 6'b10_11_00;
   localparam drive_t DRV_S4    = 6'b10_00_11;
   localparam drive_t DRV_S5    = 6'b00_10_11;
   localparam drive_t DRV_BRAKE = 6'b10_10_10;

   function automatic drive_t step_drive(input logic [3:0] step);
      case (step)
         4'd0:    return DRV_S0;
         4'd1:    return DRV_S1;
         4'd2:    return DRV_S2;
         4'd3:    return DRV_S3;
         4'd4:    return DRV_S4;
         4'd5:    return DRV_S5;
         default: return DRV_OFF;
      endcase
   endfunction

   function automatic logic [3:0] step_next(input logic [3:0] step, input logic dir);
      if (dir)
         return (step >= STEP_MAX) ? 4'd0 : step + 4'd1;
      else
         return (step == 4'd0) ? STEP_MAX : step - 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/motoro3_period_ramp.sv
// ---------------------------------------------------------------------------
// motoro3_period_ramp : moves the step period at most RAMP_DELTA toward the floored target
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module motoro3_period_ramp #(
   parameter int CNT_W      = 25,
   parameter int MIN_PERIOD = 64,
   parameter int RAMP_DELTA = 8
) (
   input  logic [CNT_W-1:0] cur,
   input  logic [CNT_W-1:0] tgt,
   output logic [CNT_W-1:0] nxt
);

   localparam int               WIDE_W  = CNT_W + 1;
   localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] DELTA_N = CNT_W'(RAMP_DELTA);
   localparam logic [CNT_W:0]   DELTA_W = WIDE_W'(RAMP_DELTA);

   logic [CNT_W-1:0] goal;
   logic [CNT_W:0]   up_sum;
   logic [CNT_W-1:0] down_gap;

   // The up-path sum is one bit wider and is clipped to goal, which never
   // exceeds 2^CNT_W-1, so the add saturates without wrapping.
   always_comb begin
      goal     = (tgt < MIN_P) ? MIN_P : tgt;
      up_sum   = {1'b0, cur} + DELTA_W;
      down_gap = cur - goal;
      nxt      = cur;
      if (cur < goal)
         nxt = (up_sum > {1'b0, goal}) ? goal : up_sum[CNT_W-1:0];
      else if (cur > goal)
         nxt = (down_gap > DELTA_N) ? cur - DELTA_N : goal;
   end

endmodule

`default_nettype wire

// File: rtl/motoro3_commutator_ramp.sv
// ---------------------------------------------------------------------------
// motoro3_commutator_ramp : six-step 3-phase commutator with period ramp, dead time and brake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module motoro3_commutator_ramp
   import motoro3_commutator_ramp_pkg::*;
#(
   parameter int CNT_W        = 25,
   parameter int DEAD_CYC     = 20,
   parameter int START_PERIOD = 2000,
   parameter int MIN_PERIOD   = 64,
   parameter int RAMP_DELTA   = 8
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             m3start,
   input  logic             m3brake,
   input  logic             m3dir,
   input  logic [CNT_W-1:0] m3periodTgt,
   output logic             aE,
   output logic             bE,
   output logic             cE,
   output logic             aH1_L0,
   output logic             bH1_L0,
   output logic             cH1_L0,
   output logic [3:0]       m3step,
   output logic [CNT_W-1:0] m3cnt,
   output logic             m3cntLast1,
   output logic [CNT_W-1:0] m3period,
   output logic [1:0]       m3state
);

   localparam int               DW        = $clog2(DEAD_CYC + 2);
   localparam logic [DW-1:0]    DEAD_LAST = DW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] START_P   = CNT_W'(START_PERIOD);
   // With no dead time the gap state is bypassed and the target is entered directly.
   localparam logic [1:0]       GAP_RUN   = (DEAD_CYC == 0) ? ST_RUN   : ST_DEAD;
   localparam logic [1:0]       GAP_BRAKE = (DEAD_CYC == 0) ? ST_BRAKE : ST_DEAD;

   logic [DW-1:0]    dcnt;
   logic             pend;
   drive_t           drv;

   logic [1:0]       nxt_state;
   logic [3:0]       nxt_step;
   logic [CNT_W-1:0] nxt_cnt;
   logic [CNT_W-1:0] nxt_period;
   logic [DW-1:0]    nxt_dcnt;
   logic             nxt_pend;
   logic             nxt_last1;
   drive_t           nxt_drv;
   logic [CNT_W-1:0] ramp_period;
   logic             step_end;

   motoro3_period_ramp #(
      .CNT_W      (CNT_W),
      .MIN_PERIOD (MIN_PERIOD),
      .RAMP_DELTA (RAMP_DELTA)
   ) u_ramp (
      .cur (m3period),
      .tgt (m3periodTgt),
      .nxt (ramp_period)
   );

   assign step_end = (m3cnt == m3period - 1'b1);

   always_comb begin
      nxt_state  = m3state;
      nxt_step   = m3step;
      nxt_cnt    = m3cnt;
      nxt_period = m3period;
      nxt_dcnt   = dcnt;
      nxt_pend   = pend;
      case (m3state)
         ST_IDLE: begin
            nxt_cnt = '0;
            if (m3brake) begin
               nxt_state = ST_BRAKE;
            end else if (m3start) begin
               nxt_state  = GAP_RUN;
               nxt_period = START_P;
               nxt_dcnt   = '0;
               nxt_pend   = 1'b0;
            end
         end
         ST_DEAD: begin
            if (m3brake)
               nxt_pend = 1'b1;
            if (!m3brake && !m3start) begin
               nxt_state = ST_IDLE;
               nxt_pend  = 1'b0;
               nxt_cnt   = '0;
            end else if (dcnt == DEAD_LAST) begin
               nxt_state = (pend || m3brake) ? ST_BRAKE : ST_RUN;
               nxt_pend  = 1'b0;
               nxt_dcnt  = '0;
               nxt_cnt   = '0;
            end else begin
               nxt_dcnt = dcnt + 1'b1;
            end
         end
         ST_RUN: begin
            nxt_dcnt = '0;
            if (!m3brake && !m3start) begin
               nxt_state = ST_IDLE;
               nxt_cnt   = '0;
            end else if (step_end) begin
               // Brake coinciding with a step end still commits the step and ramp.
               nxt_step   = step_next(m3step, m3dir);
               nxt_period = ramp_period;
               nxt_cnt    = '0;
               nxt_state  = m3brake ? GAP_BRAKE : GAP_RUN;
               nxt_pend   = m3brake;
            end else if (m3brake) begin
               nxt_state = GAP_BRAKE;
               nxt_pend  = 1'b1;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = m3cnt + 1'b1;
            end
         end
         default: begin
            nxt_cnt = '0;
            if (!m3brake)
               nxt_state = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      nxt_drv = DRV_OFF;
      if (nxt_state == ST_RUN)
         nxt_drv = step_drive(nxt_step);
      else if (nxt_state == ST_BRAKE)
         nxt_drv = DRV_BRAKE;
      nxt_last1 = (nxt_state == ST_RUN) && (nxt_cnt == nxt_period - 1'b1);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         m3state    <= ST_IDLE;
         m3step     <= 4'd0;
         m3cnt      <= '0;
         m3period   <= START_P;
         m3cntLast1 <= 1'b0;
         dcnt       <= '0;
         pend       <= 1'b0;
         drv        <= DRV_OFF;
      end else begin
         m3state    <= nxt_state;
         m3step     <= nxt_step;
         m3cnt      <= nxt_cnt;
         m3period   <= nxt_period;
         m3cntLast1 <= nxt_last1;
         dcnt       <= nxt_dcnt;
         pend       <= nxt_pend;
         drv        <= nxt_drv;
      end
   end

   assign aE     = drv.a_e;
   assign aH1_L0 = drv.a_h;
   assign bE     = drv.b_e;
   assign bH1_L0 = drv.b_h;
   assign cE     = drv.c_e;
   assign cH1_L0 = drv.c_h;

endmodule

`default_nettype wire

// File: tb/tb_motoro3_commutator_ramp.sv
// ---------------------------------------------------------------------------
// tb_motoro3_commutator_ramp : directed checks of sequencing, ramp, direction, brake and reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_motoro3_commutator_ramp;

   localparam int CNT_W = 25;
   localparam int DEAD  = 20;
   // Shorter start period keeps every ramp sequence within a few thousand clocks.
   localparam int START = 200;

   logic             clk     = 1'b0;
   logic             nRst    = 1'b1;
   logic             m3start = 1'b0;
   logic             m3brake = 1'b0;
   logic             m3dir   = 1'b1;
   logic [CNT_W-1:0] m3periodTgt = 25'd200;

   logic             aE, bE, cE, aH1_L0, bH1_L0, cH1_L0;
   logic [3:0]       m3step;
   logic [CNT_W-1:0] m3cnt;
   logic             m3cntLast1;
   logic [CNT_W-1:0] m3period;
   logic [1:0]       m3state;
   logic [5:0]       drv;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_lo [3];
   logic mon_en = 1'b0;

   int ramp_dn [13] = '{192, 184, 176, 168, 160, 152, 144, 136, 128, 120, 112, 104, 100};
   int ramp_lo [6]  = '{92, 84, 76, 68, 64, 64};
   int ramp_up [4]  = '{72, 80, 88, 90};

   motoro3_commutator_ramp #(
      .CNT_W        (CNT_W),
      .DEAD_CYC     (DEAD),
      .START_PERIOD (START),
      .MIN_PERIOD   (64),
      .RAMP_DELTA   (8)
   ) dut (
      .clk         (clk),
      .nRst        (nRst),
      .m3start     (m3start),
      .m3brake     (m3brake),
      .m3dir       (m3dir),
      .m3periodTgt (m3periodTgt),
      .aE          (aE),
      .bE          (bE),
      .cE          (cE),
      .aH1_L0      (aH1_L0),
      .bH1_L0      (bH1_L0),
      .cH1_L0      (cH1_L0),
      .m3step      (m3step),
      .m3cnt       (m3cnt),
      .m3cntLast1  (m3cntLast1),
      .m3period    (m3period),
      .m3state     (m3state)
   );

   assign drv = {aE, aH1_L0, bE, bH1_L0, cE, cH1_L0};

   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step_finish();
      for (int i = 0; i < 400; i++) begin
         if (m3cntLast1) break;
         tick(1);
      end
      check("last1 seen", 32'(m3cntLast1), 32'd1);
      tick(1);
      check("gap after step", 32'(m3state), 32'd1);
   endtask

   // A phase that was low must stay undriven for more than DEAD clocks before going high.
   always @(negedge clk) begin
      logic [2:0] pe, ph, viol;
      cyc++;
      pe = {aE, bE, cE};
      ph = {aH1_L0, bH1_L0, cH1_L0};
      viol = 3'b000;
      for (int p = 0; p < 3; p++) begin
         if (!pe[p] && ph[p])
            viol[p] = 1'b1;
         else if (pe[p] && !ph[p])
            last_lo[p] = cyc;
         else if (pe[p] && ph[p] && (cyc - last_lo[p] <= DEAD))
            viol[p] = 1'b1;
      end
      if (mon_en)
         check("shoot-through", 32'(viol), 32'd0);
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int p = 0; p < 3; p++) last_lo[p] = -1000;
      #2 nRst = 1'b0;
      tick(2);
      check("rst state",  32'(m3state),    32'd0);
      check("rst drive",  32'(drv),        32'd0);
      check("rst step",   32'(m3step),     32'd0);
      check("rst cnt",    32'(m3cnt),      32'd0);
      check("rst last1",  32'(m3cntLast1), 32'd0);
      check("rst period", 32'(m3period),   32'd200);
      mon_en = 1'b1;
      nRst   = 1'b1;
      tick(1);
      check("idle hold", 32'(m3state), 32'd0);

      // start: dead gap, step 0 for one period, dead gap, step 1
      m3start = 1'b1;
      tick(1);
      check("t1 dead",       32'(m3state),  32'd1);
      check("t1 dead drv",   32'(drv),      32'd0);
      check("t1 period",     32'(m3period), 32'd200);
      tick(19);
      check("t1 dead end",   32'(m3state),  32'd1);
      check("t1 dead end d", 32'(drv),      32'd0);
      tick(1);
      check("t1 run",        32'(m3state),  32'd2);
      check("t1 step0",      32'(m3step),   32'd0);
      check("t1 drv0",       32'(drv),      32'b111000);
      check("t1 cnt0",       32'(m3cnt),    32'd0);
      tick(199);
      check("t1 cnt last",   32'(m3cnt),    32'd199);
      check("t1 last1",      32'(m3cntLast1), 32'd1);
      check("t1 drv0 end",   32'(drv),      32'b111000);
      tick(1);
      check("t1 gap2",       32'(m3state),  32'd1);
      check("t1 step1",      32'(m3step),   32'd1);
      check("t1 gap2 drv",   32'(drv),      32'd0);
      check("t1 last1 off",  32'(m3cntLast1), 32'd0);
      tick(20);
      check("t1 run2",       32'(m3state),  32'd2);
      check("t1 drv1",       32'(drv),      32'b110010);

      // direction: sampled only at step end, wraps both ways
      tick(100);
      m3dir = 1'b0;
      tick(1);
      check("t3 dir mid",   32'(m3step), 32'd1);
      step_finish();
      check("t3 rev 1->0",  32'(m3step), 32'd0);
      tick(20);
      check("t3 drv0",      32'(drv),    32'b111000);
      step_finish();
      check("t3 wrap 0->5", 32'(m3step), 32'd5);
      tick(20);
      check("t3 drv5",      32'(drv),    32'b001011);
      m3dir = 1'b1;
      step_finish();
      check("t3 wrap 5->0", 32'(m3step), 32'd0);

      // ramp down to 100, clamp at MIN_PERIOD, ramp up without overshoot
      m3periodTgt = 25'd100;
      for (int k = 0; k < 13; k++) begin
         step_finish();
         check("t2 ramp down", 32'(m3period), 32'(ramp_dn[k]));
      end
      m3periodTgt = 25'd10;
      for (int k = 0; k < 6; k++) begin
         step_finish();
         check("t2 ramp floor", 32'(m3period), 32'(ramp_lo[k]));
      end
      m3periodTgt = 25'd90;
      for (int k = 0; k < 4; k++) begin
         step_finish();
         check("t2 ramp up", 32'(m3period), 32'(ramp_up[k]));
      end

      // brake mid-run: full dead gap, then all low sides
      tick(20);
      check("t4 run",       32'(m3state), 32'd2);
      tick(10);
      m3brake = 1'b1;
      tick(1);
      check("t4 gap",       32'(m3state), 32'd1);
      check("t4 gap drv",   32'(drv),     32'd0);
      tick(19);
      check("t4 gap end",   32'(m3state), 32'd1);
      check("t4 gap end d", 32'(drv),     32'd0);
      tick(1);
      check("t4 brake",     32'(m3state), 32'd3);
      check("t4 brake drv", 32'(drv),     32'b101010);
      m3brake = 1'b0;
      m3start = 1'b0;
      tick(1);
      check("t4 release",   32'(m3state), 32'd0);
      check("t4 rel drv",   32'(drv),     32'd0);
      m3brake = 1'b1;
      tick(1);
      check("t4 idle brake", 32'(drv),    32'b101010);
      m3brake = 1'b0;
      tick(1);
      check("t4 idle rel",  32'(m3state), 32'd0);

      // stop while running drops straight to idle
      m3start = 1'b1;
      tick(21);
      check("stop run",     32'(m3state), 32'd2);
      m3start = 1'b0;
      tick(1);
      check("stop idle",    32'(m3state), 32'd0);
      check("stop drv",     32'(drv),     32'd0);
      check("stop cnt",     32'(m3cnt),   32'd0);

      // asynchronous reset mid-gap and mid-run
      m3start = 1'b1;
      tick(6);
      check("t5 in gap",    32'(m3state),  32'd1);
      nRst = 1'b0;
      #1;
      check("t5 rst state", 32'(m3state),  32'd0);
      check("t5 rst period", 32'(m3period), 32'd200);
      check("t5 rst step",  32'(m3step),   32'd0);
      nRst = 1'b1;
      tick(1);
      check("t5 restart",   32'(m3state),  32'd1);
      tick(20);
      check("t5 run",       32'(m3state),  32'd2);
      check("t5 run drv",   32'(drv),      32'b111000);
      tick(50);
      nRst = 1'b0;
      #1;
      check("t5 rst drv",   32'(drv),      32'd0);
      check("t5 rst cnt",   32'(m3cnt),    32'd0);
      check("t5 rst st2",   32'(m3state),  32'd0);
      nRst = 1'b1;
      tick(1);
      check("t5 regap",     32'(m3state),  32'd1);
      check("t5 regap drv", 32'(drv),      32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
